swervolf_panel_in: RTL
======================

Name: swervolf_panel_in

Overview:
- Front-panel input conditioner for the Nexys A7 SweRVolf top: synchronises raw slide-switch/push-button pins into the clk_core domain and debounces them.
- Produces per-bit rise/fall pulses and sticky event flags with write-one-to-clear, plus a level interrupt.
- Feeds the CPU GPIO input and interrupt line; it is the input-side counterpart of the seven-segment/LED output path.

Parameters:
- WIDTH, 16, number of input bits
- SYNC_STAGES, 2, flip-flop stages in each synchroniser (legal range 2..4)
- TICK_DIV, 5000, clk cycles per sample tick (100 us at 50 MHz); legal range >= 2
- STABLE_TICKS, 10, consecutive mismatching ticks needed to accept a new level; legal range >= 1
- RESET_VAL, {WIDTH{1'b0}}, value loaded into the synchronisers and o_stable at reset

Ports:
- clk  in  1  core clock (clk_core)
- rstn  in  1  asynchronous active-low reset
- i_raw  in  WIDTH  raw asynchronous pin levels
- i_rise_en  in  WIDTH  per-bit enable for latching rising events
- i_fall_en  in  WIDTH  per-bit enable for latching falling events
- i_event_clr  in  WIDTH  write-one-to-clear strobe for o_pending, one cycle per write
- o_stable  out  WIDTH  debounced level
- o_rise  out  WIDTH  one-cycle pulse when o_stable goes 0->1
- o_fall  out  WIDTH  one-cycle pulse when o_stable goes 1->0
- o_pending  out  WIDTH  sticky event flags
- o_irq  out  1  OR-reduction of o_pending

Behaviour:
- Reset, asynchronous on rstn low:
  - synchroniser stages and o_stable = RESET_VAL
  - prescaler, all debounce counters, o_rise, o_fall and o_pending = 0; o_irq = 0
  - no edge pulse is produced as a consequence of reset or its release
- Synchroniser: SYNC_STAGES flops per bit; the last stage is sync[i].
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps
  - tick is high for exactly one cycle when the count equals TICK_DIV-1
  - the first tick occurs TICK_DIV cycles after reset release
- Per-bit debounce, registered and evaluated only on tick cycles:
  - sync==o_stable: cnt <= 0.
  - sync!=o_stable and cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - sync!=o_stable and cnt == STABLE_TICKS-1: o_stable <= sync, cnt <= 0, and the matching edge pulse is asserted in the same cycle o_stable changes.
  - With STABLE_TICKS=1, any mismatch seen at a tick is accepted at that tick.
- Counter width: $clog2(STABLE_TICKS+1); it never exceeds STABLE_TICKS-1.
- A bounce that returns to the o_stable level before acceptance restarts the count from 0. Glitches that land entirely between ticks are invisible.
- Latency from an i_raw step to the o_stable change: SYNC_STAGES cycles plus between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles.
- o_rise/o_fall: registered, high for exactly one cycle, mutually exclusive per bit.
- o_pending[i]:
  - set <= (o_rise[i]&i_rise_en[i]) | (o_fall[i]&i_fall_en[i]), evaluated in the cycle the pulse is high, so the flag is visible the next cycle
  - cleared by i_event_clr[i]
  - set and clear in the same cycle: set wins (the flag stays 1)
  - enable bits gate setting only; deasserting an enable does not clear a flag
- o_irq: combinational OR of the o_pending registers, with no extra latency.
- Bits are fully independent. Simultaneous edges on several bits are all reported in the same cycle.

Decomposition:
- Package swervolf_panel_pkg holds:
  - default constants PANEL_WIDTH=16, PANEL_TICK_DIV=5000, PANEL_STABLE_TICKS=10
  - a helper function for the counter width
- Sub-module swervolf_debounce_bit holds the synchroniser, counter, stable flop and edge pulses for one bit. It takes tick as an input and is instantiated WIDTH times via generate.
- The prescaler, pending flags and irq stay in the top module.

Test Plan (bench parameters TICK_DIV=4, STABLE_TICKS=3, WIDTH=16, SYNC_STAGES=2):
- Reset with RESET_VAL=16'h0000 and i_raw=16'hFFFF held through reset release -> outputs 0 during reset; o_stable=16'hFFFF after at most 2+12 cycles of released reset (the first tick arrives 4 cycles after release). A single o_rise=16'hFFFF pulse is produced, since the change is a debounced edge, not a reset artefact.
- Bit 3 steps 0->1 and holds, i_rise_en=16'h0008 -> o_stable[3] rises 11..14 cycles after the step. o_rise[3] is high for 1 cycle, o_pending=16'h0008 the next cycle, o_irq=1.
- Bit 3 toggles on each tick for 8 ticks, then settles back to its original level -> o_stable[3] unchanged; no o_rise, o_fall or o_pending activity.
- i_event_clr=16'h0008 asserted in the same cycle as a new o_fall[3], with i_fall_en[3]=1 -> o_pending[3] stays 1. A later one-cycle i_event_clr pulse -> o_pending[3]=0 the next cycle and o_irq=0.
- Bits 0 and 15 fall together, i_fall_en=16'h0001 -> o_fall=16'h8001 in the same cycle; o_pending=16'h0001 only.
- rstn pulsed low mid-count, after 2 of 3 mismatching ticks -> counters cleared and o_stable=RESET_VAL at once. After release a full 3-tick window is needed before acceptance.

Source files
------------

// File: rtl/swervolf_panel_pkg.sv
// Shared constants and sizing helpers for the SweRVolf front-panel input conditioner.
package swervolf_panel_pkg;

    localparam int unsigned PANEL_WIDTH        = 16;
    localparam int unsigned PANEL_TICK_DIV     = 5000;
    localparam int unsigned PANEL_STABLE_TICKS = 10;

    // Debounce counter width; the counter only ever holds 0..stable_ticks-1.
    function automatic int unsigned cnt_width(input int unsigned stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/swervolf_debounce_bit.sv
// One panel input bit: synchroniser, tick-sampled debounce counter, stable level and edge pulses.
module swervolf_debounce_bit
    import swervolf_panel_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STABLE_TICKS = PANEL_STABLE_TICKS,
    parameter logic        RESET_BIT    = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned      CNT_W   = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // A mismatch must persist for STABLE_TICKS consecutive ticks; any match restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_stable <= RESET_BIT;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_tick) begin
                if (w_sync == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_MAX) begin
                    r_stable <= w_sync;
                    r_cnt    <= '0;
                    r_rise   <= w_sync;
                    r_fall   <= ~w_sync;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/swervolf_panel_in.sv
// Front-panel input conditioner: per-bit debounce, sticky W1C event flags and a level interrupt.
module swervolf_panel_in
    import swervolf_panel_pkg::*;
#(
    parameter int unsigned      WIDTH        = PANEL_WIDTH,
    parameter int unsigned      SYNC_STAGES  = 2,
    parameter int unsigned      TICK_DIV     = PANEL_TICK_DIV,
    parameter int unsigned      STABLE_TICKS = PANEL_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_raw,
    input  logic [WIDTH-1:0] i_rise_en,
    input  logic [WIDTH-1:0] i_fall_en,
    input  logic [WIDTH-1:0] i_event_clr,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_pending,
    output logic             o_irq
);

    localparam int unsigned      PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] r_pending;

    assign w_tick = (r_pre == PRE_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        swervolf_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_BIT    (RESET_VAL[g])
        ) u_db (
            .clk      (clk),
            .rstn     (rstn),
            .i_raw    (i_raw[g]),
            .i_tick   (w_tick),
            .o_stable (o_stable[g]),
            .o_rise   (o_rise[g]),
            .o_fall   (o_fall[g])
        );
    end

    assign w_set = (o_rise & i_rise_en) | (o_fall & i_fall_en);

    // A new event in the same cycle as its clear keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~i_event_clr) | w_set;
        end
    end

    assign o_pending = r_pending;
    assign o_irq     = |r_pending;

endmodule
